// File: rtl/wbs_gpio_target.sv
// wbs_gpio_target: Wishbone classic slave with ID, scratch, GPIO out/oe, a synchronized GPIO input
// with rising-edge interrupts and a free-running cycle counter. Define WBT_ERR_EN to error unmapped offsets.
module wbs_gpio_target #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFC0,
  parameter logic [31:0] ID_VALUE  = 32'h4C42_0001
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  input  logic [15:0] io_in,
  output logic [15:0] io_out,
  output logic [15:0] io_oeb,
  output logic        irq
);

  localparam logic [3:0] OFF_ID      = 4'd0;
  localparam logic [3:0] OFF_SCRATCH = 4'd1;
  localparam logic [3:0] OFF_OUT     = 4'd2;
  localparam logic [3:0] OFF_OE      = 4'd3;
  localparam logic [3:0] OFF_IN      = 4'd4;
  localparam logic [3:0] OFF_CNT     = 4'd5;
  localparam logic [3:0] OFF_STAT    = 4'd6;
  localparam logic [3:0] OFF_MASK    = 4'd7;

  logic [31:0] scratch;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oe;
  logic [31:0] cycle_cnt;
  logic [15:0] sync_1;
  logic [15:0] sync_2;
  logic [15:0] sync_prev;
  logic [15:0] irq_stat;
  logic [15:0] irq_mask;
  logic        ack_q;
  logic        err_q;
  logic [31:0] dat_q;
  logic        irq_q;

  logic        selected;
  logic        busy;
  logic        accept;
  logic [3:0]  offset;
  logic        mapped;
  logic        wr_en;
  logic [31:0] byte_mask;
  logic [31:0] rd_data;
  logic [15:0] rise;
  logic [15:0] stat_clear;

  assign selected  = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign busy      = ack_q | err_q;
  assign accept    = selected & ~busy;
  assign offset    = wbs_adr_i[5:2];
  assign mapped    = ~offset[3];
  assign wr_en     = accept & wbs_we_i & mapped;
  assign byte_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  assign rise       = sync_2 & ~sync_prev;
  assign stat_clear = (wr_en && offset == OFF_STAT) ? (wbs_dat_i[15:0] & byte_mask[15:0]) : 16'd0;

  always_comb begin
    rd_data = 32'd0;
    case (offset)
      OFF_ID:      rd_data = ID_VALUE;
      OFF_SCRATCH: rd_data = scratch;
      OFF_OUT:     rd_data = {16'd0, gpio_out};
      OFF_OE:      rd_data = {16'd0, gpio_oe};
      OFF_IN:      rd_data = {16'd0, sync_2};
      OFF_CNT:     rd_data = cycle_cnt;
      OFF_STAT:    rd_data = {16'd0, irq_stat};
      OFF_MASK:    rd_data = {16'd0, irq_mask};
      default:     rd_data = 32'd0;
    endcase
  end

  // Busy blocks re-acceptance, so a held strobe yields one pulse every other cycle.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q <= 1'b0;
      dat_q <= 32'd0;
    end else begin
`ifdef WBT_ERR_EN
      ack_q <= accept & mapped;
      dat_q <= (accept && !wbs_we_i && mapped) ? rd_data : 32'd0;
`else
      ack_q <= accept;
      dat_q <= (accept && !wbs_we_i) ? rd_data : 32'd0;
`endif
    end
  end

`ifdef WBT_ERR_EN
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept & ~mapped;
    end
  end
`else
  assign err_q = 1'b0;
`endif

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      scratch  <= 32'd0;
      gpio_out <= 16'd0;
      gpio_oe  <= 16'd0;
      irq_mask <= 16'd0;
    end else if (wr_en) begin
      case (offset)
        OFF_SCRATCH: scratch  <= (scratch & ~byte_mask) | (wbs_dat_i & byte_mask);
        OFF_OUT:     gpio_out <= (gpio_out & ~byte_mask[15:0]) | (wbs_dat_i[15:0] & byte_mask[15:0]);
        OFF_OE:      gpio_oe  <= (gpio_oe & ~byte_mask[15:0]) | (wbs_dat_i[15:0] & byte_mask[15:0]);
        OFF_MASK:    irq_mask <= (irq_mask & ~byte_mask[15:0]) | (wbs_dat_i[15:0] & byte_mask[15:0]);
        default: ;
      endcase
    end
  end

  // A firmware write replaces the increment for that cycle.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= 32'd0;
    end else if (wr_en && offset == OFF_CNT) begin
      cycle_cnt <= (cycle_cnt & ~byte_mask) | (wbs_dat_i & byte_mask);
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // Edge-set is ORed after the clear so a coincident edge survives a W1C.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1    <= 16'd0;
      sync_2    <= 16'd0;
      sync_prev <= 16'd0;
      irq_stat  <= 16'd0;
      irq_q     <= 1'b0;
    end else begin
      sync_1    <= io_in;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      irq_stat  <= (irq_stat & ~stat_clear) | rise;
      irq_q     <= |(irq_stat & irq_mask);
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = gpio_out;
  assign io_oeb    = ~gpio_oe;
  assign irq       = irq_q;

endmodule

// File: tb/tb_wbs_gpio_target.sv
// Scoreboard bench for wbs_gpio_target: stimulus pushes expected bus responses, a monitor pops
// and compares them; a register-level reference model supplies all expected values.
module tb_wbs_gpio_target;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] ID   = 32'h4C42_0001;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'd0;
  logic [31:0] wbs_dat_i = 32'd0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic [15:0] io_in = 16'd0;
  logic [15:0] io_out;
  logic [15:0] io_oeb;
  logic        irq;

  wbs_gpio_target dut (
    .mclk(mclk), .reset_n(reset_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
  );

  always #5 mclk = ~mclk;

  int total = 0;
  int bad = 0;
  int unsigned tb_cycle = 0;
  always @(posedge mclk) tb_cycle <= tb_cycle + 1;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
    string       name;
  } resp_t;
  resp_t sb_q[$];

  // Reference model: register contents plus the counter expressed as (value, cycle it was valid from)
  logic [31:0] m_scratch;
  logic [15:0] m_out, m_oe, m_stat, m_mask, m_io;
  logic [31:0] cnt_base;
  int unsigned cnt_cycle;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_scratch = 32'd0;
    m_out = 16'd0; m_oe = 16'd0; m_stat = 16'd0; m_mask = 16'd0; m_io = io_in;
    cnt_base = 32'd0;
    cnt_cycle = tb_cycle;
  endtask

  // n is the cycle index before the sampling edge; reads see state as of edge n
  function automatic logic [31:0] model_read(input logic [3:0] off, input int unsigned n);
    case (off)
      4'd0: return ID;
      4'd1: return m_scratch;
      4'd2: return {16'd0, m_out};
      4'd3: return {16'd0, m_oe};
      4'd4: return {16'd0, m_io};
      4'd5: return cnt_base + 32'(n - cnt_cycle);
      4'd6: return {16'd0, m_stat};
      4'd7: return {16'd0, m_mask};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [3:0] off, input logic [31:0] data, input logic [3:0] sel, input int unsigned n);
    logic [31:0] t;
    case (off)
      4'd1: m_scratch = byte_merge(m_scratch, data, sel);
      4'd2: begin t = byte_merge({16'd0, m_out}, data, sel); m_out = t[15:0]; end
      4'd3: begin t = byte_merge({16'd0, m_oe}, data, sel); m_oe = t[15:0]; end
      4'd5: begin cnt_base = byte_merge(model_read(4'd5, n), data, sel); cnt_cycle = n + 1; end
      4'd6: begin t = byte_merge(32'd0, data, sel); m_stat = m_stat & ~t[15:0]; end
      4'd7: begin t = byte_merge({16'd0, m_mask}, data, sel); m_mask = t[15:0]; end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                               input logic [31:0] data, input string name);
    int unsigned n;
    int          kind;
    logic [31:0] exp_data;
    logic [3:0]  off;
    resp_t       r;
    @(negedge mclk);
    n = tb_cycle;
    off = addr[5:2];
    exp_data = 32'd0;
    kind = 0;
    if ((addr & 32'hFFFF_FFC0) == BASE) begin
      kind = 1;
      if (off >= 4'd8) begin
`ifdef WBT_ERR_EN
        kind = 2;
`endif
      end else if (we) begin
        model_write(off, data, sel, n);
      end else begin
        exp_data = model_read(off, n);
      end
    end
    wbs_adr_i = addr; wbs_we_i = we; wbs_sel_i = sel; wbs_dat_i = data;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    if (kind != 0) begin
      r.is_err = (kind == 2); r.data = exp_data; r.name = name;
      sb_q.push_back(r);
    end
    @(posedge mclk); #1;
    checkOutput({name, "/latency"}, {30'd0, wbs_err_o, wbs_ack_o}, 32'(kind));
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge mclk); #1;
    checkOutput({name, "/pulse"}, {30'd0, wbs_err_o, wbs_ack_o}, 32'd0);
    checkOutput({name, "/dat_idle"}, wbs_dat_o, 32'd0);
  endtask

  task automatic set_io(input logic [15:0] v, input bit update_model);
    @(negedge mclk);
    if (update_model) m_stat = m_stat | (v & ~m_io);
    m_io = v;
    io_in = v;
  endtask

  task automatic check_irq(input string name);
    checkOutput(name, {31'd0, irq}, {31'd0, |(m_stat & m_mask)});
  endtask

  always @(negedge mclk) begin : monitor
    resp_t r;
    if (reset_n && (wbs_ack_o || wbs_err_o)) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_resp actual ack=%0b err=%0b required no response", wbs_ack_o, wbs_err_o);
      end else begin
        r = sb_q.pop_front();
        checkOutput({r.name, "/kind"}, {31'd0, wbs_err_o}, {31'd0, r.is_err});
        checkOutput({r.name, "/data"}, wbs_dat_o, r.data);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    logic [31:0] d;
    logic [3:0]  s;
    logic [15:0] v;
    int unsigned m;

    repeat (3) @(posedge mclk);
    @(negedge mclk);
    reset_n = 1'b1;
    model_reset();
    #1;
    checkOutput("rst/dat_o", wbs_dat_o, 32'd0);
    checkOutput("rst/ack", {31'd0, wbs_ack_o}, 32'd0);
    checkOutput("rst/err", {31'd0, wbs_err_o}, 32'd0);
    checkOutput("rst/io_out", {16'd0, io_out}, 32'd0);
    checkOutput("rst/io_oeb", {16'd0, io_oeb}, 32'h0000_FFFF);
    checkOutput("rst/irq", {31'd0, irq}, 32'd0);

    applyStimulus(BASE + 32'h00, 1'b0, 4'hF, 32'd0, "id_read");

    applyStimulus(BASE + 32'h0C, 1'b1, 4'hF, 32'h0000_FFFF, "oe_wr");
    applyStimulus(BASE + 32'h08, 1'b1, 4'hF, 32'h0000_AB60, "out_wr0");
    checkOutput("io_out_ab60", {16'd0, io_out}, 32'h0000_AB60);
    applyStimulus(BASE + 32'h08, 1'b1, 4'hF, 32'h0000_AB61, "out_wr1");
    checkOutput("io_out_ab61", {16'd0, io_out}, 32'h0000_AB61);
    checkOutput("io_oeb_on", {16'd0, io_oeb}, 32'd0);
    applyStimulus(BASE + 32'h08, 1'b0, 4'hF, 32'd0, "out_rd");
    applyStimulus(BASE + 32'h0C, 1'b0, 4'hF, 32'd0, "oe_rd");
    applyStimulus(BASE + 32'h08, 1'b1, 4'hF, 32'hDEAD_1234, "out_upper_ignored");
    applyStimulus(BASE + 32'h08, 1'b0, 4'hF, 32'd0, "out_upper_rd");

    applyStimulus(BASE + 32'h04, 1'b1, 4'hF, 32'hFFFF_FFFF, "scr_full");
    applyStimulus(BASE + 32'h04, 1'b1, 4'b0010, 32'h0000_1200, "scr_byte1");
    applyStimulus(BASE + 32'h04, 1'b0, 4'hF, 32'd0, "scr_rd");
    checkOutput("scr_model", m_scratch, 32'hFFFF_12FF);

    applyStimulus(BASE + 32'h14, 1'b1, 4'hF, 32'hFFFF_FFFE, "cnt_wr");
    @(posedge mclk);
    applyStimulus(BASE + 32'h14, 1'b0, 4'hF, 32'd0, "cnt_wrap_rd");

    applyStimulus(BASE + 32'h1C, 1'b1, 4'hF, 32'h0000_0001, "mask_wr");
    set_io(16'h0001, 1'b1);
    m = tb_cycle;
    repeat (3) @(negedge mclk);
    checkOutput("irq_edge+3", {31'd0, irq}, 32'd0);
    @(negedge mclk);
    checkOutput("irq_edge+4", {31'd0, irq}, 32'd1);
    checkOutput("irq_cycles", tb_cycle - m, 32'd4);
    applyStimulus(BASE + 32'h10, 1'b0, 4'hF, 32'd0, "gpio_in_rd");
    applyStimulus(BASE + 32'h18, 1'b0, 4'hF, 32'd0, "stat_rd");

    set_io(16'h0000, 1'b1);
    repeat (5) @(negedge mclk);
    set_io(16'h0001, 1'b0);
    @(negedge mclk);
    applyStimulus(BASE + 32'h18, 1'b1, 4'hF, 32'h0000_0001, "w1c_vs_edge");
    m_stat = m_stat | 16'h0001;
    applyStimulus(BASE + 32'h18, 1'b0, 4'hF, 32'd0, "stat_kept");
    check_irq("irq_kept");
    applyStimulus(BASE + 32'h18, 1'b1, 4'hF, 32'h0000_0001, "w1c_clear");
    applyStimulus(BASE + 32'h18, 1'b0, 4'hF, 32'd0, "stat_cleared");
    check_irq("irq_cleared");

    for (int i = 0; i < 40; i++) begin
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 5))
        0: begin
          applyStimulus(BASE + 32'h04, 1'b1, s, d, "rnd_scr_wr");
          applyStimulus(BASE + 32'h04, 1'b0, 4'hF, 32'd0, "rnd_scr_rd");
        end
        1: begin
          applyStimulus(BASE + 32'h08, 1'b1, s, d, "rnd_out_wr");
          checkOutput("rnd_io_out", {16'd0, io_out}, {16'd0, m_out});
        end
        2: begin
          applyStimulus(BASE + 32'h0C, 1'b1, s, d, "rnd_oe_wr");
          checkOutput("rnd_io_oeb", {16'd0, io_oeb}, {16'd0, ~m_oe});
        end
        3: begin
          applyStimulus(BASE + 32'h1C, 1'b1, s, d, "rnd_mask_wr");
          check_irq("rnd_irq_mask");
        end
        4: begin
          v = 16'($urandom);
          set_io(v, 1'b1);
          repeat (5) @(negedge mclk);
          applyStimulus(BASE + 32'h10, 1'b0, 4'hF, 32'd0, "rnd_in_rd");
          applyStimulus(BASE + 32'h18, 1'b0, 4'hF, 32'd0, "rnd_stat_rd");
          check_irq("rnd_irq_io");
        end
        default: begin
          applyStimulus(BASE + 32'h18, 1'b1, s, d, "rnd_w1c");
          applyStimulus(BASE + 32'h18, 1'b0, 4'hF, 32'd0, "rnd_stat_rd2");
          check_irq("rnd_irq_w1c");
        end
      endcase
    end
    applyStimulus(BASE + 32'h14, 1'b0, 4'hF, 32'd0, "rnd_cnt_rd");

    // Strobe held across the ack: pulse, gap, then a second acceptance
    @(negedge mclk);
    wbs_adr_i = BASE; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    begin
      resp_t r;
      r.is_err = 1'b0; r.data = ID; r.name = "hold1"; sb_q.push_back(r);
      r.name = "hold2"; sb_q.push_back(r);
    end
    @(posedge mclk); #1;
    checkOutput("hold/ack1", {31'd0, wbs_ack_o}, 32'd1);
    @(posedge mclk); #1;
    checkOutput("hold/gap", {31'd0, wbs_ack_o}, 32'd0);
    @(posedge mclk); #1;
    checkOutput("hold/ack2", {31'd0, wbs_ack_o}, 32'd1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge mclk); #1;
    checkOutput("hold/end", {31'd0, wbs_ack_o}, 32'd0);

    applyStimulus(BASE + 32'h20, 1'b0, 4'hF, 32'd0, "unmapped_rd");
    applyStimulus(BASE + 32'h3C, 1'b1, 4'hF, 32'h1234_5678, "unmapped_wr");
    applyStimulus(BASE + 32'h40, 1'b0, 4'hF, 32'd0, "outside_rd");
    applyStimulus(32'h2000_0004, 1'b1, 4'hF, 32'hFFFF_FFFF, "outside_wr");
    applyStimulus(BASE + 32'h04, 1'b0, 4'hF, 32'd0, "scr_after_unmapped");

    // Reset lands while the ack for a scratch write is on the bus
    set_io(16'h0000, 1'b1);
    repeat (4) @(negedge mclk);
    wbs_adr_i = BASE + 32'h04; wbs_we_i = 1'b1; wbs_sel_i = 4'hF; wbs_dat_i = 32'hCAFE_F00D;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    @(posedge mclk); #1;
    checkOutput("midrst/ack_before", {31'd0, wbs_ack_o}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("midrst/ack_cleared", {31'd0, wbs_ack_o}, 32'd0);
    checkOutput("midrst/io_oeb", {16'd0, io_oeb}, 32'h0000_FFFF);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    repeat (2) @(posedge mclk);
    @(negedge mclk);
    reset_n = 1'b1;
    model_reset();
    repeat (2) begin
      @(posedge mclk); #1;
      checkOutput("midrst/no_ack", {30'd0, wbs_err_o, wbs_ack_o}, 32'd0);
    end
    applyStimulus(BASE + 32'h04, 1'b0, 4'hF, 32'd0, "midrst/scr_rd");
    applyStimulus(BASE + 32'h14, 1'b0, 4'hF, 32'd0, "midrst/cnt_rd");

    repeat (3) @(negedge mclk);
    checkOutput("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wbs_gpio_target.md
# wbs_gpio_target

Wishbone classic slave for the user project. It terminates management-SoC firmware accesses arriving through the user-project Wishbone port and exposes a small register bank. The bank holds an ID, a scratch register, a 16-bit GPIO checkpoint bus mapped onto mprj_io[31:16], a synchronized GPIO input with edge interrupts, and a free-running cycle counter.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000, base of the 64-byte register window
- ADDR_MASK, 32'hFFFF_FFC0, bits compared against BASE_ADDR for selection
- ID_VALUE, 32'h4C42_0001, read-only ID register contents

Ports:
- mclk  in  1  single clock (Wishbone clock)
- reset_n  in  1  asynchronous, active-low reset
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_dat_o  out  32  read data
- wbs_ack_o  out  1  acknowledge
- wbs_err_o  out  1  error (only with WBT_ERR_EN)
- io_in  in  16  asynchronous pad inputs
- io_out  out  16  GPIO_OUT register
- io_oeb  out  16  active-low output enables (inverse of GPIO_OE)
- irq  out  1  level interrupt

## Operation
- Selection: cyc & stb & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR). Unselected requests get no response.
- Register map, decoded from wbs_adr_i[5:2]:
  - 0x00 ID: RO
  - 0x04 SCRATCH: RW, reset 0
  - 0x08 GPIO_OUT[15:0]: RW, reset 0
  - 0x0C GPIO_OE[15:0]: RW, reset 0
  - 0x10 GPIO_IN[15:0]: RO
  - 0x14 CYCLE_CNT[31:0]: RW, reset 0
  - 0x18 IRQ_STAT[15:0]: W1C, reset 0
  - 0x1C IRQ_MASK[15:0]: RW, reset 0
- Unmapped offsets are 0x20–0x3C.
- Writes honour wbs_sel_i per byte. Bits [31:16] of the 16-bit registers read 0, and writes to them are ignored.
- GPIO_IN is io_in after a 2-flop synchronizer (reset 0).
- IRQ_STAT[k] sets on a rising edge of synchronized bit k (previous-value flop, reset 0).
- irq = |(IRQ_STAT & IRQ_MASK). irq is registered.
- CYCLE_CNT increments every cycle and wraps from 32'hFFFF_FFFF to 0.
- Reset values of outputs: wbs_dat_o 0, wbs_ack_o 0, wbs_err_o 0, io_out 0, io_oeb 16'hFFFF, irq 0.

## Timing
- Response latency: ack/err asserts the cycle after a selected request is first sampled. It is a one-cycle pulse and deasserts even if stb is held.
- A new request is accepted only while ack/err is low. Minimum access period is 2 cycles.
- wbs_dat_o is registered alongside ack. It is 0 whenever ack is low and 0 for writes.
- Write effects are visible at the ack edge. A read issued immediately after a write returns the new value.
- CYCLE_CNT: a write in the same cycle as an increment wins. The counter resumes incrementing from the written value on the next cycle.
- IRQ_STAT: an edge-set and a W1C on the same bit in the same cycle leaves the bit set.
- GPIO_IN: an edge on io_in appears in GPIO_IN after 2 cycles. IRQ_STAT sets on the 3rd cycle and irq asserts on the 4th.
- If cyc drops while ack is pending, the ack pulse still issues once. The master ignores it.
- Reset asserted mid-transaction clears all state immediately. No ack is produced after reset release for the aborted access.

## Configuration
- WBT_ERR_EN defined:
  - An access to an unmapped offset returns a one-cycle wbs_err_o pulse instead of ack. dat_o is 0 and writes are ignored.
- WBT_ERR_EN not defined:
  - wbs_err_o is tied to 0.
  - An access to an unmapped offset acks normally, reads return 0 and writes are ignored.

## Test plan
- Reset, then read 0x3000_0000 → ID 32'h4C42_0001, ack exactly 1 cycle after stb. Outputs otherwise at reset values (io_oeb 16'hFFFF).
- Write GPIO_OE=16'hFFFF and GPIO_OUT=16'hAB60, then 16'hAB61 → io_out shows AB60 then AB61, io_oeb=0. Readback matches.
- Write SCRATCH=32'hFFFF_FFFF, then sel=4'b0010 data 32'h0000_1200 → read 32'hFFFF_12FF.
- Write CYCLE_CNT=32'hFFFF_FFFE, then read it 3 cycles later → wrap observed, value small (≤3) and deterministic. The bench computes the exact value.
- Set IRQ_MASK=16'h0001 and pulse io_in[0] high → irq high 4 cycles after the edge. W1C of bit 0 concurrent with a fresh edge → IRQ_STAT[0] remains 1.
- Access 0x3000_0020:
  - WBT_ERR_EN defined: err pulse, no ack.
  - WBT_ERR_EN not defined: ack with data 0.
  - Either way, 0x3000_0040 gets no response.
